// File: rtl/multicycle_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit_pkg
// Shared definitions for the multi-cycle RV32I control unit. Extends the
// opcode/ALU set of the single-cycle decoder with the sequencer state
// encoding and the PC-source / write-back mux select constants.
// No ports (package).
// -----------------------------------------------------------------------------
package multicycle_control_unit_pkg;

  localparam int ALU_W = 5;

  // RV32I major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALUControl encodings
  localparam logic [ALU_W-1:0] ALU_NOP  = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'd2;
  localparam logic [ALU_W-1:0] ALU_SLL  = 5'd3;
  localparam logic [ALU_W-1:0] ALU_SLT  = 5'd4;
  localparam logic [ALU_W-1:0] ALU_SLTU = 5'd5;
  localparam logic [ALU_W-1:0] ALU_XOR  = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SRL  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SRA  = 5'd8;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'd9;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'd10;

  // PCSrc selects
  localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
  localparam logic [1:0] PCSRC_IMM   = 2'b01;
  localparam logic [1:0] PCSRC_JALR  = 2'b10;

  // MemtoReg selects
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  // Sequencer states; the encoding is visible on state_o for debug
  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB     = 3'b100,
    ST_TRAP   = 3'b110
  } state_t;

  // Second ALU operand comes from the immediate for everything except
  // R-type, branches and JAL.
  function automatic logic uses_imm(input logic [6:0] op);
    return (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_op_decoder.sv
// -----------------------------------------------------------------------------
// alu_op_decoder
// Purely combinational: maps opcode/func3/func7 to the ALU operation and
// flags whether the encoding is one this core implements.
// Ports:
//   opcode  in  7   instruction [6:0]
//   func3   in  3   instruction [14:12]
//   func7   in  7   instruction [31:25]
//   alu_op  out 5   ALU operation (ALU_* encodings)
//   legal   out 1   1 = known opcode and, for R-type, a listed func7/func3
// -----------------------------------------------------------------------------
module alu_op_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  output logic [ALU_W-1:0] alu_op,
  output logic             legal
);

  // Table lookup; anything not listed decodes to NOP and is reported illegal.
  always_comb begin
    alu_op = ALU_NOP;
    legal  = 1'b1;
    case (opcode)
      OP_R: begin
        case ({func7, func3})
          {7'b0000000, 3'b000}: alu_op = ALU_ADD;
          {7'b0100000, 3'b000}: alu_op = ALU_SUB;
          {7'b0000000, 3'b001}: alu_op = ALU_SLL;
          {7'b0000000, 3'b010}: alu_op = ALU_SLT;
          {7'b0000000, 3'b011}: alu_op = ALU_SLTU;
          {7'b0000000, 3'b100}: alu_op = ALU_XOR;
          {7'b0000000, 3'b101}: alu_op = ALU_SRL;
          {7'b0100000, 3'b101}: alu_op = ALU_SRA;
          {7'b0000000, 3'b110}: alu_op = ALU_OR;
          {7'b0000000, 3'b111}: alu_op = ALU_AND;
          default:              legal  = 1'b0;
        endcase
      end
      OP_I: begin
        case (func3)
          3'b000: alu_op = ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          // bit 30 separates the arithmetic shift from the logical one
          3'b101: alu_op = func7[5] ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
        endcase
      end
      OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JALR: alu_op = ALU_ADD;
      OP_BRANCH: alu_op = ALU_SUB;
      // JAL target comes from the dedicated PC+imm adder, ALU idles
      OP_JAL:    alu_op = ALU_NOP;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Sequences FETCH/DECODE/EXEC/MEM/WB for a shared-datapath RV32I core and
// drives every datapath enable and mux select. Memory waits are bounded by
// a counter; on timeout bus_err pulses and the instruction is refetched.
// Optional build macro: ILLEGAL_TRAP_EN adds a TRAP state and illegal_o.
// Ports:
//   clk, reset (sync, active-high)
//   instruction_code  IR contents        imem_ready/dmem_ready  memory ready
//   branch_taken      comparator result  imem_req, IRWrite, PCWrite, PCSrc
//   ALUSrc, ALUControl, MemRead, MemWrite, MemtoReg, RegWrite, bus_err
//   illegal_o (ILLEGAL_TRAP_EN only), state_o (debug state encoding)
// -----------------------------------------------------------------------------
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ALU_CTRL_W = ALU_W,
  parameter int WAIT_MAX   = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    instruction_code,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  branch_taken,
  output logic                  imem_req,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic [1:0]            PCSrc,
  output logic                  ALUSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [1:0]            MemtoReg,
  output logic                  RegWrite,
  output logic                  bus_err,
`ifdef ILLEGAL_TRAP_EN
  output logic                  illegal_o,
`endif
  output logic [2:0]            state_o
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [6:0]       func7;
  logic [ALU_W-1:0] alu_op;
  logic             legal;
  logic             is_load;
  logic             is_store;
  logic             waiting;
  logic             timeout;
  logic             unused_fields;

  assign opcode   = instruction_code[6:0];
  assign func3    = instruction_code[14:12];
  assign func7    = instruction_code[31:25];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign unused_fields = ^{instruction_code[24:15], instruction_code[11:7]};

  alu_op_decoder u_alu_op_decoder (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .alu_op (alu_op),
    .legal  (legal)
  );

  // A wait cycle is one where the state is stalled on a memory handshake.
  // Timeout fires only when the counter is already at WAIT_MAX and ready
  // is still low, so a ready in that same cycle wins.
  assign waiting = ((state == ST_FETCH) && !imem_ready) ||
                   ((state == ST_MEM)   && !dmem_ready);
  assign timeout = waiting && (wait_cnt == CNT_W'(WAIT_MAX));

  // State register and wait counter. The counter is cleared on every
  // transition (including the timeout restart of FETCH) and only runs
  // while stalled on a ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else if (timeout) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else if (waiting) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
      case (state)
        ST_FETCH:  state <= ST_DECODE;
`ifdef ILLEGAL_TRAP_EN
        ST_DECODE: state <= legal ? ST_EXEC : ST_TRAP;
`else
        ST_DECODE: state <= ST_EXEC;
`endif
        ST_EXEC: begin
          if ((opcode == OP_BRANCH) || !legal) state <= ST_FETCH;
          else if (is_load || is_store)        state <= ST_MEM;
          else                                 state <= ST_WB;
        end
        ST_MEM:  state <= is_load ? ST_WB : ST_FETCH;
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Output decode from state + opcode. Requests are dropped on a timeout;
  // the write/latch enables are forced low while reset is asserted so the
  // reset cycle never commits PC, IR or register-file state.
  always_comb begin
    imem_req   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = PCSRC_PLUS4;
    ALUSrc     = 1'b0;
    ALUControl = ALU_CTRL_W'(ALU_NOP);
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = M2R_ALU;
    RegWrite   = 1'b0;
    bus_err    = timeout;
`ifdef ILLEGAL_TRAP_EN
    illegal_o  = 1'b0;
`endif
    case (state)
      ST_FETCH: begin
        imem_req = !timeout;
        IRWrite  = imem_ready;
      end
      ST_EXEC: begin
        ALUControl = ALU_CTRL_W'(alu_op);
        ALUSrc     = uses_imm(opcode);
        if (opcode == OP_BRANCH) begin
          PCWrite = 1'b1;
          PCSrc   = branch_taken ? PCSRC_IMM : PCSRC_PLUS4;
        end else if (!legal) begin
          PCWrite = 1'b1;
        end
      end
      ST_MEM: begin
        MemRead  = is_load  && !timeout;
        MemWrite = is_store && !timeout;
        PCWrite  = is_store && dmem_ready;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        if (is_load)                                      MemtoReg = M2R_MEM;
        else if ((opcode == OP_JAL) || (opcode == OP_JALR)) MemtoReg = M2R_PC4;
        if (opcode == OP_JAL)       PCSrc = PCSRC_IMM;
        else if (opcode == OP_JALR) PCSrc = PCSRC_JALR;
      end
`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: illegal_o = 1'b1;
`endif
      default: ;
    endcase
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      bus_err  = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed-vector bench for multicycle_control_unit built with WAIT_MAX=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled 3 units
// later, well away from the next edge. Expected values are hand-derived
// literals (ALU codes: NOP=0 ADD=1 SUB=2 SRA=8; states F=0 D=1 E=2 M=3 W=4
// TRAP=6).
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_code;
  logic        imem_ready;
  logic        dmem_ready;
  logic        branch_taken;
  logic        imem_req;
  logic        IRWrite;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        ALUSrc;
  logic [4:0]  ALUControl;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemtoReg;
  logic        RegWrite;
  logic        bus_err;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_o;
`endif
  logic [2:0]  state_o;

  int testsRun    = 0;
  int testsFailed = 0;

  multicycle_control_unit #(
    .INSTR_W    (32),
    .ALU_CTRL_W (5),
    .WAIT_MAX   (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .instruction_code (instruction_code),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .branch_taken     (branch_taken),
    .imem_req         (imem_req),
    .IRWrite          (IRWrite),
    .PCWrite          (PCWrite),
    .PCSrc            (PCSrc),
    .ALUSrc           (ALUSrc),
    .ALUControl       (ALUControl),
    .MemRead          (MemRead),
    .MemWrite         (MemWrite),
    .MemtoReg         (MemtoReg),
    .RegWrite         (RegWrite),
    .bus_err          (bus_err),
`ifdef ILLEGAL_TRAP_EN
    .illegal_o        (illegal_o),
`endif
    .state_o          (state_o)
  );

  always #5 clk = ~clk;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic ir, input logic dr, input logic bt);
    instruction_code = instr;
    imem_ready       = ir;
    dmem_ready       = dr;
    branch_taken     = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  // F, D, E, W sequence for instructions that finish with a register write.
  task automatic runWbInstr(input string name, input logic [31:0] instr, input logic chkAlu,
                            input logic [4:0] expAlu, input logic expSrc,
                            input logic [1:0] expPcSrc, input logic [1:0] expM2R);
    applyStimulus(instr, 1'b1, 1'b0, 1'b0);
    #3;
    checkOutput({name, " F state"}, 32'(state_o), 32'd0);
    checkOutput({name, " F IRWrite"}, 32'(IRWrite), 32'd1);
    tick(); #3;
    checkOutput({name, " D state"}, 32'(state_o), 32'd1);
    checkOutput({name, " D PCWrite"}, 32'(PCWrite), 32'd0);
    tick(); #3;
    checkOutput({name, " E state"}, 32'(state_o), 32'd2);
    if (chkAlu) checkOutput({name, " E ALUControl"}, 32'(ALUControl), 32'(expAlu));
    checkOutput({name, " E ALUSrc"}, 32'(ALUSrc), 32'(expSrc));
    checkOutput({name, " E RegWrite"}, 32'(RegWrite), 32'd0);
    tick(); #3;
    checkOutput({name, " W state"}, 32'(state_o), 32'd4);
    checkOutput({name, " W RegWrite"}, 32'(RegWrite), 32'd1);
    checkOutput({name, " W PCWrite"}, 32'(PCWrite), 32'd1);
    checkOutput({name, " W PCSrc"}, 32'(PCSrc), 32'(expPcSrc));
    checkOutput({name, " W MemtoReg"}, 32'(MemtoReg), 32'(expM2R));
    checkOutput({name, " W MemRead"}, 32'(MemRead), 32'd0);
    tick(); #3;
    checkOutput({name, " next F state"}, 32'(state_o), 32'd0);
  endtask

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    doReset();
    #3;
    checkOutput("reset state", 32'(state_o), 32'd0);
    checkOutput("reset imem_req", 32'(imem_req), 32'd1);
    checkOutput("reset IRWrite", 32'(IRWrite), 32'd0);
    checkOutput("reset PCWrite", 32'(PCWrite), 32'd0);
    checkOutput("reset RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("reset MemRead", 32'(MemRead), 32'd0);
    checkOutput("reset MemWrite", 32'(MemWrite), 32'd0);
    checkOutput("reset ALUControl", 32'(ALUControl), 32'd0);
    checkOutput("reset PCSrc", 32'(PCSrc), 32'd0);
    checkOutput("reset MemtoReg", 32'(MemtoReg), 32'd0);
    checkOutput("reset bus_err", 32'(bus_err), 32'd0);
    tick();

    // Register-writing instructions, zero-wait memory (4 cycles each)
    runWbInstr("ADD",  32'h002081B3, 1'b1, 5'd1, 1'b0, 2'b00, 2'b00);
    runWbInstr("SUB",  32'h402081B3, 1'b1, 5'd2, 1'b0, 2'b00, 2'b00);
    runWbInstr("ADDI", 32'h00500093, 1'b1, 5'd1, 1'b1, 2'b00, 2'b00);
    runWbInstr("SRAI", 32'h4050D093, 1'b1, 5'd8, 1'b1, 2'b00, 2'b00);
    runWbInstr("LUI",  32'h000010B7, 1'b1, 5'd1, 1'b1, 2'b00, 2'b00);
    runWbInstr("JAL",  32'h000000EF, 1'b0, 5'd0, 1'b0, 2'b01, 2'b10);
    runWbInstr("JALR", 32'h000100E7, 1'b1, 5'd1, 1'b1, 2'b10, 2'b10);

    // LW with dmem_ready arriving 3 cycles after MEM entry: 8 cycles total
    applyStimulus(32'h0000A283, 1'b1, 1'b0, 1'b0);
    #3;
    checkOutput("LW F IRWrite", 32'(IRWrite), 32'd1);
    tick(); #3;
    checkOutput("LW D state", 32'(state_o), 32'd1);
    tick(); #3;
    checkOutput("LW E ALUControl", 32'(ALUControl), 32'd1);
    checkOutput("LW E ALUSrc", 32'(ALUSrc), 32'd1);
    checkOutput("LW E MemRead", 32'(MemRead), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ready = 1'b1;
      #3;
      checkOutput($sformatf("LW M%0d state", i + 1), 32'(state_o), 32'd3);
      checkOutput($sformatf("LW M%0d MemRead", i + 1), 32'(MemRead), 32'd1);
      checkOutput($sformatf("LW M%0d PCWrite", i + 1), 32'(PCWrite), 32'd0);
      tick();
    end
    dmem_ready = 1'b0;
    #3;
    checkOutput("LW W state", 32'(state_o), 32'd4);
    checkOutput("LW W MemtoReg", 32'(MemtoReg), 32'd1);
    checkOutput("LW W RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("LW W MemRead", 32'(MemRead), 32'd0);
    tick(); #3;
    checkOutput("LW next F state", 32'(state_o), 32'd0);

    // BEQ taken then not taken (3 cycles each)
    for (int t = 1; t >= 0; t--) begin
      applyStimulus(32'h00208463, 1'b1, 1'b0, t[0]);
      #3;
      checkOutput("BEQ F state", 32'(state_o), 32'd0);
      tick(); tick(); #3;
      checkOutput($sformatf("BEQ%0d E state", t), 32'(state_o), 32'd2);
      checkOutput($sformatf("BEQ%0d E ALUControl", t), 32'(ALUControl), 32'd2);
      checkOutput($sformatf("BEQ%0d E PCWrite", t), 32'(PCWrite), 32'd1);
      checkOutput($sformatf("BEQ%0d E PCSrc", t), 32'(PCSrc), (t == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("BEQ%0d E RegWrite", t), 32'(RegWrite), 32'd0);
      tick(); #3;
      checkOutput($sformatf("BEQ%0d next F state", t), 32'(state_o), 32'd0);
    end

    // Fetch timeout: bus_err in the 5th FETCH cycle, request dropped
    doReset();
    for (int i = 0; i < 4; i++) begin
      #3;
      checkOutput($sformatf("TO c%0d bus_err", i + 1), 32'(bus_err), 32'd0);
      checkOutput($sformatf("TO c%0d imem_req", i + 1), 32'(imem_req), 32'd1);
      tick();
    end
    #3;
    checkOutput("TO c5 bus_err", 32'(bus_err), 32'd1);
    checkOutput("TO c5 imem_req", 32'(imem_req), 32'd0);
    checkOutput("TO c5 PCWrite", 32'(PCWrite), 32'd0);
    checkOutput("TO c5 IRWrite", 32'(IRWrite), 32'd0);
    tick(); #3;
    checkOutput("TO restart state", 32'(state_o), 32'd0);
    checkOutput("TO restart bus_err", 32'(bus_err), 32'd0);
    checkOutput("TO restart imem_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick(); #3;
      checkOutput($sformatf("TO2 c%0d bus_err", i + 2), 32'(bus_err), 32'd0);
    end
    // Ready arrives in the would-be timeout cycle: ready wins
    tick();
    applyStimulus(32'h002081B3, 1'b1, 1'b0, 1'b0);
    #3;
    checkOutput("TO2 c5 bus_err", 32'(bus_err), 32'd0);
    checkOutput("TO2 c5 IRWrite", 32'(IRWrite), 32'd1);
    tick(); #3;
    checkOutput("TO2 next state", 32'(state_o), 32'd1);

    // SW with reset in the 2nd MEM cycle (dmem_ready high to prove gating)
    doReset();
    applyStimulus(32'h0020A023, 1'b1, 1'b0, 1'b0);
    tick(); tick(); #3;
    checkOutput("SW E ALUSrc", 32'(ALUSrc), 32'd1);
    checkOutput("SW E MemWrite", 32'(MemWrite), 32'd0);
    tick(); #3;
    checkOutput("SW M1 state", 32'(state_o), 32'd3);
    checkOutput("SW M1 MemWrite", 32'(MemWrite), 32'd1);
    checkOutput("SW M1 PCWrite", 32'(PCWrite), 32'd0);
    tick();
    reset = 1'b1;
    dmem_ready = 1'b1;
    #3;
    checkOutput("SW rst PCWrite", 32'(PCWrite), 32'd0);
    checkOutput("SW rst RegWrite", 32'(RegWrite), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(32'h0020A023, 1'b0, 1'b0, 1'b0);
    #3;
    checkOutput("SW post-rst state", 32'(state_o), 32'd0);
    checkOutput("SW post-rst MemWrite", 32'(MemWrite), 32'd0);
    checkOutput("SW post-rst PCWrite", 32'(PCWrite), 32'd0);
    checkOutput("SW post-rst imem_req", 32'(imem_req), 32'd1);

    // Unknown opcode
    doReset();
    applyStimulus(32'h0000007F, 1'b1, 1'b0, 1'b0);
    #3;
    checkOutput("ILL F IRWrite", 32'(IRWrite), 32'd1);
    tick(); #3;
    checkOutput("ILL D state", 32'(state_o), 32'd1);
    tick(); #3;
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("TRAP c%0d state", i), 32'(state_o), 32'd6);
      checkOutput($sformatf("TRAP c%0d illegal_o", i), 32'(illegal_o), 32'd1);
      checkOutput($sformatf("TRAP c%0d PCWrite", i), 32'(PCWrite), 32'd0);
      checkOutput($sformatf("TRAP c%0d imem_req", i), 32'(imem_req), 32'd0);
      checkOutput($sformatf("TRAP c%0d RegWrite", i), 32'(RegWrite), 32'd0);
      tick(); #3;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #3;
    checkOutput("TRAP post-rst state", 32'(state_o), 32'd0);
    checkOutput("TRAP post-rst illegal_o", 32'(illegal_o), 32'd0);
`else
    checkOutput("ILL E state", 32'(state_o), 32'd2);
    checkOutput("ILL E PCWrite", 32'(PCWrite), 32'd1);
    checkOutput("ILL E PCSrc", 32'(PCSrc), 32'd0);
    checkOutput("ILL E RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("ILL E ALUControl", 32'(ALUControl), 32'd0);
    tick(); #3;
    checkOutput("ILL next F state", 32'(state_o), 32'd0);
    checkOutput("ILL next imem_req", 32'(imem_req), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle RV32I decoder. A state machine sequences FETCH/DECODE/EXEC/MEM/WB for a shared-datapath core. It adds ready/request handshakes to the instruction and data memories, a bounded wait counter with a bus-error report, and PC-write/PC-source control.
The block sits between the instruction register, the ALU branch comparator and the memory ports. It drives every datapath enable and mux select.

Parameters:
INSTR_W, 32, instruction width decoded (opcode/func3/func7 fields taken from RV32I positions)
ALU_CTRL_W, 5, width of ALUControl (encodings from shared package)
WAIT_MAX, 15, max cycles spent waiting on a memory ready before bus_err; wait counter width = $clog2(WAIT_MAX+1)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
instruction_code  in  INSTR_W  IR contents; valid from DECODE onward
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
branch_taken  in  1  comparator result for current B-type (func3-resolved in datapath)
imem_req  out  1  instruction fetch request
IRWrite  out  1  latch fetched word into IR
PCWrite  out  1  update PC this cycle
PCSrc  out  2  00 PC+4, 01 PC+imm (branch/JAL), 10 ALU result & ~1 (JALR)
ALUSrc  out  1  0 rs2, 1 imm
ALUControl  out  ALU_CTRL_W  ALU op
MemRead  out  1  data load request
MemWrite  out  1  data store request
MemtoReg  out  2  00 ALU, 01 memory, 10 PC+4
RegWrite  out  1  register-file write enable
bus_err  out  1  one-cycle pulse on memory wait timeout
state_o  out  3  current state encoding (debug)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. On a reset edge: state<=FETCH, wait counter<=0.
- Outputs are combinational from state+opcode. Post-reset values: imem_req=1; all other outputs 0; ALUControl=ALU_NOP; PCSrc=00; MemtoReg=00.
- FETCH: imem_req=1.
  - imem_ready=1 -> IRWrite=1 same cycle, go to DECODE.
  - Otherwise the wait counter increments.
- DECODE: 1 cycle, no enables. Go to EXEC.
- EXEC: ALUControl and ALUSrc as the single-cycle decoder produces (R/I-arith table, ADD for load/store/LUI/AUIPC/JALR, SUB for B).
  - B: PCWrite=1; PCSrc=01 if branch_taken, else 00; go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - LOAD: MemRead=1 held until dmem_ready; then go to WB.
  - STORE: MemWrite=1 held until dmem_ready; then PCWrite=1, PCSrc=00, go to FETCH.
- WB: RegWrite=1, PCWrite=1, go to FETCH.
  - MemtoReg: 01 for LOAD, 10 for JAL/JALR, else 00.
  - PCSrc: 01 for JAL, 10 for JALR, else 00.
- Latency with zero-wait memory (cycles from FETCH entry to next FETCH): R/I/LUI/AUIPC/JAL/JALR 4, LOAD 5, STORE 4, B 3. Each wait cycle adds 1.
- Wait counter:
  - Counts only while in FETCH with imem_ready=0, or MEM with dmem_ready=0.
  - Cleared on every state change.
  - If the counter equals WAIT_MAX and ready is still 0: bus_err=1 for one cycle, drop the request, go to FETCH with no PCWrite (instruction retried). Ready arriving in that same cycle wins: no bus_err.
- Unknown opcode, feature off: EXEC treats it as NOP; WB is skipped with RegWrite=0; PCWrite=1, PCSrc=00 in EXEC; go to FETCH (3 cycles).
- Reset asserted in any state, including mid-MEM with MemWrite high: the next edge forces FETCH. The request drops the cycle after reset is sampled. No PCWrite or RegWrite is issued in the reset cycle; outputs are gated by reset.
- MemRead/MemWrite are never asserted outside MEM. RegWrite is never asserted outside WB.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: adds TRAP state (state_o=3'b110) and output illegal_o (1 bit).
  - Unknown opcode, or R-type with an unlisted func7/func3, in DECODE -> TRAP.
  - TRAP: illegal_o=1, all enables 0, held until reset.
- Undefined: no TRAP state, no illegal_o port; behaviour as in the unknown-opcode bullet above.

Decomposition:
- Shared package (extends the existing opcode/ALU define set): OP_* opcodes, ALU_* encodings, state enum typedef (FETCH, DECODE, EXEC, MEM, WB, TRAP), PCSrc and MemtoReg encoding constants.
- One combinational sub-module, alu_op_decoder: opcode/func3/func7 -> ALUControl + legal flag. Instantiated once.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ready=1 -> states F,D,E,W. In EXEC: ALUControl=ALU_ADD, ALUSrc=0. In W (cycle 4): RegWrite=1, PCWrite=1, PCSrc=00.
- LW x5,0(x1) (0x0000A283), dmem_ready rises 3 cycles after MEM entry -> MemRead high 4 cycles, then WB with MemtoReg=01; total 8 cycles.
- BEQ (0x00208463) with branch_taken=1 -> EXEC: ALUControl=ALU_SUB, PCWrite=1, PCSrc=01, no RegWrite. With branch_taken=0 -> PCSrc=00.
- WAIT_MAX=4, imem_ready held 0 -> bus_err pulses in the 5th FETCH cycle and FETCH restarts. Repeat with imem_ready=1 in that same cycle -> IRWrite=1, no bus_err.
- SW (0x0020A023), reset asserted in the 2nd MEM cycle -> MemWrite=0 and state FETCH after the edge; no PCWrite seen.
- 0x0000007F -> feature off: 3-cycle NOP with PCWrite=1, PCSrc=00. Feature on: TRAP, illegal_o=1 held until reset.
